pipe_stage_reg: RTL and testbench
=================================

// Module: pipe_stage_reg
// PURPOSE
//  Generic pipeline stage register that replaces fixed per-stage registers (IF/ID..MEM/WB).
//  Carries a control field and a data payload with valid/ready handshake, synchronous flush
//  and an optional 2-entry skid buffer. Invalid slots present all-zero control, i.e. bubbles.
//  Counts back-pressure cycles for performance monitoring.
// PARAMETERS
//  CTRL_W       2   control bits (RegWrite, MemtoReg, ...); forced to 0 when slot invalid/flushed
//  DATA_W       69  payload bits (e.g. rdata32 + alu32 + wn5); never gated, held on flush
//  SKID         1   1: registered in_ready, 2 entries; 0: single entry, combinational in_ready
//  STALL_CNT_W  16  width of saturating stall counter
// PORTS
//  clk        in   1            rising-edge clock
//  reset      in   1            asynchronous, active-high reset
//  flush      in   1            synchronous kill of all held entries
//  in_valid   in   1            upstream entry valid
//  in_ready   out  1            stage can accept this cycle
//  in_ctrl    in   CTRL_W       upstream control field
//  in_data    in   DATA_W       upstream payload
//  out_valid  out  1            head entry valid
//  out_ready  in   1            downstream accepts head
//  out_ctrl   out  CTRL_W       head control; 0 whenever out_valid=0
//  out_data   out  DATA_W       head payload (don't-care when out_valid=0)
//  stall_cnt  out  STALL_CNT_W  cycles with out_valid=1 & out_ready=0, saturating
// BEHAVIOUR
//  - accept = in_valid & in_ready; drain = out_valid & out_ready. Entries M (head), S (skid).
//  - Reset (async): M,S valid=0, ctrl=0, data=0; stall_cnt=0; in_ready=1 after release.
//  - Latency: accepted entry appears at out_* the next cycle (1 cycle); order strictly FIFO.
//  - States (occupancy): EMPTY, ONE, FULL (FULL only when SKID=1).
//    EMPTY: accept -> ONE (M<=in).
//    ONE: accept&drain -> ONE (M<=in); accept&!drain -> FULL (S<=in); drain only -> EMPTY.
//    FULL: drain -> ONE (M<=S); no accept possible (in_ready=0).
//  - SKID=1: in_ready is a flop = !S.valid; depends on no input combinationally.
//  - SKID=0: in_ready = !M.valid | out_ready; accept&!drain while ONE never happens.
//  - flush: highest priority after reset; next state EMPTY, both ctrl fields <=0, data held;
//    an accept in the flush cycle is discarded; a drain in the flush cycle still completes.
//  - out_ctrl = M.valid ? M.ctrl : 0 (combinational gate, no extra latency).
//  - stall_cnt +1 each cycle out_valid & !out_ready; holds at 2^STALL_CNT_W-1; only reset clears.
//  - Reset asserted mid-transfer: entries lost, no partial output; outputs 0 same cycle (async).
// STRUCTURE
//  - Shared include pipe_defs.vh: occupancy encodings (ST_EMPTY/ST_ONE/ST_FULL), default
//    CTRL_W/DATA_W per stage, reset value constants.
//  - Sub-module pipe_slot: one entry (valid, ctrl, data) with load/clear/flush ports; instanced
//    as M and S (S generated only when SKID=1). Occupancy FSM and stall counter live in top.
// TESTING
//  1 Reset: assert reset async mid-cycle -> out_valid=0, out_ctrl=0, stall_cnt=0 immediately.
//  2 Stream: out_ready=1, in_valid=1 for 8 cycles, data 0..7 -> out_data 0..7 one cycle later,
//    in_ready stays 1, stall_cnt=0.
//  3 Back-pressure (SKID=1): out_ready=0 after data 0 -> data 1 lands in S, in_ready=0 next cycle;
//    hold 5 cycles -> stall_cnt=5; release -> 0 then 1 emitted, no loss/duplication.
//  4 Flush in FULL with in_valid=1: next cycle out_valid=0, out_ctrl=0, in_ready=1, input dropped.
//  5 Saturation: STALL_CNT_W=4, stall 20 cycles -> stall_cnt=15 and holds.
//  6 SKID=0: out_ready=0 with M full -> in_ready=0 same cycle; out_ready=1 -> accept&drain together.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_pkg
// Description : Shared occupancy encoding, default widths and reset values
//               for the generic pipeline stage register.
// Revision    : 1.0  initial release
// ============================================================================
package pipe_stage_reg_pkg;

    // Occupancy of the stage: nothing held, head only, head plus skid entry
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_e;

    localparam int DEF_CTRL_W      = 2;
    localparam int DEF_DATA_W      = 69;
    localparam int DEF_STALL_CNT_W = 16;

    // Value of a slot's valid bit coming out of reset
    localparam logic VALID_RST = 1'b0;

endpackage : pipe_stage_reg_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg_slot.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg_slot
// Description : One pipeline entry (valid, control, payload). Control is
//               zeroed whenever the entry becomes invalid; payload is only
//               written on load so it is held through flush and clear.
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg_slot
    import pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic              clear_i,
    input  logic              flush_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o
);

    logic              valid_q;
    logic [CTRL_W-1:0] ctrl_q;
    logic [DATA_W-1:0] data_q;

    // Entry storage: flush beats load beats clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= VALID_RST;
            ctrl_q  <= '0;
            data_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            ctrl_q  <= ctrl_i;
            data_q  <= data_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
            ctrl_q  <= '0;
        end
    end

    assign valid_o = valid_q;
    assign ctrl_o  = ctrl_q;
    assign data_o  = data_q;

endmodule : pipe_stage_reg_slot
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Generic valid/ready pipeline stage register with flush,
//               optional 2-entry skid buffer and saturating stall counter.
//               Invalid slots present zero control (bubbles).
// Revision    : 1.0  initial release
// ============================================================================
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int CTRL_W      = DEF_CTRL_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int SKID        = 1,
    parameter int STALL_CNT_W = DEF_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [CTRL_W-1:0]      in_ctrl,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CTRL_W-1:0]      out_ctrl,
    output logic [DATA_W-1:0]      out_data,
    output logic [STALL_CNT_W-1:0] stall_cnt
);

    localparam logic [STALL_CNT_W-1:0] STALL_MAX = '1;
    localparam logic [STALL_CNT_W-1:0] STALL_ONE = {{(STALL_CNT_W-1){1'b0}}, 1'b1};

    occ_e state_q, state_d;

    logic              m_load, m_clear, s_load, s_clear;
    logic              m_valid, s_valid;
    logic [CTRL_W-1:0] m_ctrl, s_ctrl, m_ctrl_in;
    logic [DATA_W-1:0] m_data, s_data, m_data_in;
    logic              accept, drain;

    logic [STALL_CNT_W-1:0] stall_q, stall_d;

    assign accept = in_valid & in_ready;
    assign drain  = m_valid & out_ready;

    // Head refills from the skid entry when it holds the older item
    assign m_ctrl_in = (state_q == ST_FULL) ? s_ctrl : in_ctrl;
    assign m_data_in = (state_q == ST_FULL) ? s_data : in_data;

    // Occupancy state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next occupancy and slot load/clear strobes
    always_comb begin
        state_d = state_q;
        m_load  = 1'b0;
        m_clear = 1'b0;
        s_load  = 1'b0;
        s_clear = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        m_load  = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        m_load  = 1'b1;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        s_load  = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                        m_clear = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state_d = ST_ONE;
                        m_load  = 1'b1;
                        s_clear = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    pipe_stage_reg_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_slot_m (
        .clk     (clk),
        .reset   (reset),
        .load_i  (m_load),
        .clear_i (m_clear),
        .flush_i (flush),
        .ctrl_i  (m_ctrl_in),
        .data_i  (m_data_in),
        .valid_o (m_valid),
        .ctrl_o  (m_ctrl),
        .data_o  (m_data)
    );

    generate
        if (SKID != 0) begin : g_skid
            pipe_stage_reg_slot #(
                .CTRL_W (CTRL_W),
                .DATA_W (DATA_W)
            ) u_slot_s (
                .clk     (clk),
                .reset   (reset),
                .load_i  (s_load),
                .clear_i (s_clear),
                .flush_i (flush),
                .ctrl_i  (in_ctrl),
                .data_i  (in_data),
                .valid_o (s_valid),
                .ctrl_o  (s_ctrl),
                .data_o  (s_data)
            );
            // Purely a flop output: room exists whenever the skid entry is free
            assign in_ready = ~s_valid;
        end else begin : g_noskid
            logic unused_skid_ctl;
            assign unused_skid_ctl = s_load ^ s_clear;
            assign s_valid  = 1'b0;
            assign s_ctrl   = '0;
            assign s_data   = '0;
            // Single entry: accept when empty or when the head leaves this cycle
            assign in_ready = ~m_valid | out_ready;
        end
    endgenerate

    // Saturating count of cycles the head is blocked downstream
    always_comb begin
        stall_d = stall_q;
        if (m_valid && !out_ready && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + STALL_ONE;
        end
    end

    // Stall counter register; only reset clears it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign out_valid = m_valid;
    assign out_ctrl  = m_valid ? m_ctrl : '0;
    assign out_data  = m_data;
    assign stall_cnt = stall_q;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench. Three instances share one stimulus
//               stream: skid (16-bit counter), no-skid, and skid with a
//               4-bit counter. Each is compared every cycle against a
//               small FIFO model of the stage.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int DW = 69;
    localparam int CW = 2;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } ent_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;

    logic          ov [3];
    logic          ir [3];
    logic [CW-1:0] oc [3];
    logic [DW-1:0] od [3];
    logic [15:0]   sc0, sc1;
    logic [3:0]    sc2;

    ent_t mbuf [3][2];
    int   mcnt [3];
    int   mstall [3];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .STALL_CNT_W(16)) dut0 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
        .out_ctrl(oc[0]), .out_data(od[0]), .stall_cnt(sc0));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .STALL_CNT_W(16)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
        .out_ctrl(oc[1]), .out_data(od[1]), .stall_cnt(sc1));

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .STALL_CNT_W(4)) dut2 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
        .out_ctrl(oc[2]), .out_data(od[2]), .stall_cnt(sc2));

    function automatic int cap(input int k);
        return (k == 1) ? 1 : 2;
    endfunction

    function automatic int smax(input int k);
        return (k == 2) ? 15 : 65535;
    endfunction

    function automatic logic [DW-1:0] stall_of(input int k);
        case (k)
            0:       return DW'(sc0);
            1:       return DW'(sc1);
            default: return DW'(sc2);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            mcnt[k]   = 0;
            mstall[k] = 0;
        end
    endtask

    // Called at posedge+1 with inputs set; compares at negedge, steps model, returns at next posedge+1
    task automatic tick();
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            logic          ev, er;
            logic [CW-1:0] ec;
            ev = (mcnt[k] > 0);
            ec = ev ? mbuf[k][0].c : '0;
            if (cap(k) == 2) er = (mcnt[k] < 2);
            else             er = (mcnt[k] == 0) || out_ready;
            chk($sformatf("out_valid[%0d]", k), DW'(ov[k]), DW'(ev));
            chk($sformatf("out_ctrl[%0d]", k), DW'(oc[k]), DW'(ec));
            chk($sformatf("in_ready[%0d]", k), DW'(ir[k]), DW'(er));
            chk($sformatf("stall_cnt[%0d]", k), stall_of(k), DW'(mstall[k]));
            if (ev) chk($sformatf("out_data[%0d]", k), od[k], mbuf[k][0].d);
            if (ev && !out_ready && mstall[k] < smax(k)) mstall[k]++;
            if (flush) begin
                mcnt[k] = 0;
            end else begin
                if (ev && out_ready) begin
                    mbuf[k][0] = mbuf[k][1];
                    mcnt[k]--;
                end
                if (in_valid && er) begin
                    mbuf[k][mcnt[k]] = '{c: in_ctrl, d: in_data};
                    mcnt[k]++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Async reset asserted mid-cycle; outputs must clear without waiting for a clock edge
    task automatic async_reset();
        #3 reset = 1'b1;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_out_valid[%0d]", k), DW'(ov[k]), '0);
            chk($sformatf("rst_out_ctrl[%0d]", k), DW'(oc[k]), '0);
            chk($sformatf("rst_stall[%0d]", k), stall_of(k), '0);
        end
        model_clear();
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_ctrl   = '0;
        in_data   = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", DW'(ov[0]), '0);
        reset = 1'b0;
        #1;
        chk("reset_in_ready", DW'(ir[0]), DW'(1'b1));
        chk("reset_stall", DW'(sc0), '0);

        // Streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = DW'(i);
            in_ctrl = CW'((i % 3) + 1);
            tick();
            chk("stream_data", od[0], DW'(i));
            chk("stream_ready", DW'(ir[0]), DW'(1'b1));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_stall", DW'(sc0), '0);

        // Back-pressure into the skid entry
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_ctrl   = 2'd1;
        in_data   = DW'(16'h10);
        tick();
        in_data = DW'(16'h11);
        tick();
        chk("bp_in_ready_low", DW'(ir[0]), '0);
        in_data = DW'(16'h12);
        repeat (4) tick();
        chk("bp_stall5", DW'(sc0), DW'(5));
        chk("bp_head", od[0], DW'(16'h10));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_second", od[0], DW'(16'h11));
        tick();
        chk("bp_empty", DW'(ov[0]), '0);

        // Flush while full with an incoming entry
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'd3;
        in_data   = DW'(16'h20);
        tick();
        in_data = DW'(16'h21);
        tick();
        chk("fl_full", DW'(ir[0]), '0);
        flush   = 1'b1;
        in_data = DW'(16'h22);
        tick();
        flush = 1'b0;
        chk("fl_valid", DW'(ov[0]), '0);
        chk("fl_ctrl", DW'(oc[0]), '0);
        chk("fl_ready", DW'(ir[0]), DW'(1'b1));
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("fl_dropped", DW'(ov[0]), '0);

        // Counter saturation on the 4-bit instance
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 2'd2;
        in_data   = DW'(16'h40);
        repeat (20) tick();
        chk("sat_15", DW'(sc2), DW'(15));
        tick();
        chk("sat_hold", DW'(sc2), DW'(15));

        // No-skid instance: ready follows out_ready combinationally
        chk("ns_ready_low", DW'(ir[1]), '0);
        out_ready = 1'b1;
        #1;
        chk("ns_ready_comb", DW'(ir[1]), DW'(1'b1));
        in_data = DW'(16'h30);
        tick();
        chk("ns_pass", od[1], DW'(16'h30));
        chk("ns_valid", DW'(ov[1]), DW'(1'b1));

        // Random traffic with a mid-stream reset
        for (int n = 0; n < 600; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 20) == 0;
            in_ctrl   = CW'($urandom);
            in_data   = DW'({$urandom, $urandom, $urandom});
            if (n == 300) async_reset();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire
